// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Transmitting end of the Common Data Bus.
//   Reservation stations hand in completed results. Each result is a value
//   plus the tag of the station that produced it. Results are buffered per
//   source. Every cycle one buffered result is chosen round-robin and
//   broadcast on the CDB, where registers and waiting stations capture it by
//   tag match.
//
// Parameters
//   N_SRC     number of result sources
//   DATA_W    result width
//   TAG_W     station tag width (tag 0 = "no producer")
//   DEPTH     per-source buffer depth, power of 2
//   IDLE_VAL  value driven on CDB when nothing is broadcast
//
// Ports
//   Clock      in   rising-edge clock
//   Reset      in   asynchronous active-low reset, flushes all buffers
//   Res_Valid  in   [N_SRC]        source i presents a result
//   Res_Tag    in   [N_SRC*TAG_W]  tag of source i, slice [i*TAG_W +: TAG_W]
//   Res_Data   in   [N_SRC*DATA_W] data of source i, slice [i*DATA_W +: DATA_W]
//   Res_Ready  out  [N_SRC]        source i may transfer this cycle
//   Hold       in   suppress broadcast this cycle
//   CDB        out  broadcast value (IDLE_VAL when idle)
//   Qi_CDB     out  broadcast tag (0 when idle)
//   CDB_Valid  out  one-cycle pulse per broadcast result
//   Busy       out  at least one result is still buffered

module cdb_arbiter #(
  parameter int                N_SRC    = 2,
  parameter int                DATA_W   = 16,
  parameter int                TAG_W    = 3,
  parameter int                DEPTH    = 2,
  parameter logic [DATA_W-1:0] IDLE_VAL = 16'hFFF0
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic [N_SRC-1:0]          Res_Valid,
  input  logic [N_SRC*TAG_W-1:0]    Res_Tag,
  input  logic [N_SRC*DATA_W-1:0]   Res_Data,
  output logic [N_SRC-1:0]          Res_Ready,
  input  logic                      Hold,
  output logic [DATA_W-1:0]         CDB,
  output logic [TAG_W-1:0]          Qi_CDB,
  output logic                      CDB_Valid,
  output logic                      Busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int RR_W  = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [RR_W-1:0]  LAST_SRC  = RR_W'(N_SRC - 1);

  // Per-source state exported from the generate blocks so the arbiter can
  // see every source's occupancy and head entry.
  logic [CNT_W-1:0]  count_q   [N_SRC];
  logic [TAG_W-1:0]  head_tag  [N_SRC];
  logic [DATA_W-1:0] head_data [N_SRC];

  logic [RR_W-1:0] rr_q;
  logic [RR_W-1:0] win_idx;
  logic [RR_W-1:0] scan_idx;
  logic            win_found;
  logic            busy_any;

  // Round-robin scan starting at rr_q. The first non-empty source wins.
  // Hold masks the whole search, so nothing is dequeued and rr_q stays put.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
    for (int k = 0; k < N_SRC; k++) begin
      scan_idx = RR_W'((int'(rr_q) + k) % N_SRC);
      if (!Hold && !win_found && (count_q[scan_idx] != '0)) begin
        win_found = 1'b1;
        win_idx   = scan_idx;
      end
    end
  end

  for (genvar i = 0; i < N_SRC; i++) begin : g_src
    logic [TAG_W-1:0]  tag_mem  [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [TAG_W-1:0]  in_tag;
    logic [DATA_W-1:0] in_data;
    logic              enq;
    logic              deq;

    assign in_tag  = Res_Tag[i*TAG_W +: TAG_W];
    assign in_data = Res_Data[i*DATA_W +: DATA_W];

    // Ready comes from the registered count only. A full FIFO therefore
    // stays not-ready for the whole cycle in which it is being drained.
    assign Res_Ready[i] = (count < FULL_CNT);

    // A tag-0 result completes the handshake but carries no producer, so
    // it is accepted and then dropped rather than stored.
    assign enq = Res_Valid[i] && Res_Ready[i] && (in_tag != '0);
    assign deq = win_found && (win_idx == RR_W'(i));

    // Pointer and occupancy bookkeeping. Enqueue and dequeue on the same
    // edge advance both pointers and leave the count unchanged.
    always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (enq) begin
          wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
        end
        if (deq) begin
          rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
        end
        case ({enq, deq})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end

    // Storage is not reset. An entry is only read while count says it
    // is valid.
    always_ff @(posedge Clock) begin
      if (enq) begin
        tag_mem[wr_ptr]  <= in_tag;
        data_mem[wr_ptr] <= in_data;
      end
    end

    assign count_q[i]   = count;
    assign head_tag[i]  = tag_mem[rd_ptr];
    assign head_data[i] = data_mem[rd_ptr];
  end

  // Broadcast register and round-robin pointer. The winner's head goes out
  // on this edge. Otherwise the bus returns to the idle pattern.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      CDB       <= IDLE_VAL;
      Qi_CDB    <= '0;
      CDB_Valid <= 1'b0;
      rr_q      <= '0;
    end else if (win_found) begin
      CDB       <= head_data[win_idx];
      Qi_CDB    <= head_tag[win_idx];
      CDB_Valid <= 1'b1;
      rr_q      <= (win_idx == LAST_SRC) ? '0 : win_idx + RR_W'(1);
    end else begin
      CDB       <= IDLE_VAL;
      Qi_CDB    <= '0;
      CDB_Valid <= 1'b0;
    end
  end

  // Busy reflects buffered work only, not the result currently on the bus.
  always_comb begin
    busy_any = 1'b0;
    for (int k = 0; k < N_SRC; k++) begin
      busy_any = busy_any | (count_q[k] != '0);
    end
  end

  assign Busy = busy_any;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter
//   Directed bench for cdb_arbiter with the default parameters.
//   Inputs change 1 ns after a rising edge. Outputs are sampled at the
//   same point, so each tick() moves exactly one register update forward.

module tb_cdb_arbiter;

  logic        clk;
  logic        reset;
  logic [1:0]  res_valid;
  logic [5:0]  res_tag;
  logic [31:0] res_data;
  logic [1:0]  res_ready;
  logic        hold;
  logic [15:0] cdb;
  logic [2:0]  qi_cdb;
  logic        cdb_valid;
  logic        busy;

  int total;
  int bad;

  cdb_arbiter #(
    .N_SRC    (2),
    .DATA_W   (16),
    .TAG_W    (3),
    .DEPTH    (2),
    .IDLE_VAL (16'hFFF0)
  ) dut (
    .Clock     (clk),
    .Reset     (reset),
    .Res_Valid (res_valid),
    .Res_Tag   (res_tag),
    .Res_Data  (res_data),
    .Res_Ready (res_ready),
    .Hold      (hold),
    .CDB       (cdb),
    .Qi_CDB    (qi_cdb),
    .CDB_Valid (cdb_valid),
    .Busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset low across two edges, then release it away from the edge.
  task automatic do_reset();
    reset     = 1'b0;
    res_valid = 2'b00;
    res_tag   = '0;
    res_data  = '0;
    hold      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      tick();
      total++; if (cdb !== 16'hFFF0) begin bad++; $display("[TB] FAIL reset_cdb cyc=%0d got=%h want=fff0", c, cdb); end
      total++; if (qi_cdb !== 3'd0) begin bad++; $display("[TB] FAIL reset_qi cyc=%0d got=%0d want=0", c, qi_cdb); end
      total++; if (cdb_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid cyc=%0d got=%b want=0", c, cdb_valid); end
      total++; if (res_ready !== 2'b11) begin bad++; $display("[TB] FAIL reset_ready cyc=%0d got=%b want=11", c, res_ready); end
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy cyc=%0d got=%b want=0", c, busy); end
    end
  endtask

  task automatic test_single();
    do_reset();
    res_valid = 2'b01;
    res_tag   = {3'd0, 3'd1};
    res_data  = {16'h0000, 16'h0005};
    tick();
    res_valid = 2'b00;
    total++; if (cdb_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_nobypass got=%b want=0", cdb_valid); end
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL single_busy got=%b want=1", busy); end
    tick();
    total++; if (cdb_valid !== 1'b1) begin bad++; $display("[TB] FAIL single_valid got=%b want=1", cdb_valid); end
    total++; if (cdb !== 16'h0005) begin bad++; $display("[TB] FAIL single_cdb got=%h want=0005", cdb); end
    total++; if (qi_cdb !== 3'd1) begin bad++; $display("[TB] FAIL single_qi got=%0d want=1", qi_cdb); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL single_busy_after got=%b want=0", busy); end
    tick();
    total++; if (cdb_valid !== 1'b0) begin bad++; $display("[TB] FAIL single_one_cycle got=%b want=0", cdb_valid); end
    total++; if (cdb !== 16'hFFF0) begin bad++; $display("[TB] FAIL single_idle_cdb got=%h want=fff0", cdb); end
    total++; if (qi_cdb !== 3'd0) begin bad++; $display("[TB] FAIL single_idle_qi got=%0d want=0", qi_cdb); end
  endtask

  task automatic test_contention();
    do_reset();
    for (int rep = 0; rep < 2; rep++) begin
      res_valid = 2'b11;
      res_tag   = {3'd2, 3'd1};
      res_data  = {16'h0022, 16'h0011};
      tick();
      res_valid = 2'b00;
      total++; if (cdb_valid !== 1'b0) begin bad++; $display("[TB] FAIL cont_nobypass rep=%0d got=%b want=0", rep, cdb_valid); end
      tick();
      total++; if (qi_cdb !== 3'd1) begin bad++; $display("[TB] FAIL cont_first_qi rep=%0d got=%0d want=1", rep, qi_cdb); end
      total++; if (cdb !== 16'h0011) begin bad++; $display("[TB] FAIL cont_first_cdb rep=%0d got=%h want=0011", rep, cdb); end
      total++; if (cdb_valid !== 1'b1) begin bad++; $display("[TB] FAIL cont_first_valid rep=%0d got=%b want=1", rep, cdb_valid); end
      total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL cont_busy rep=%0d got=%b want=1", rep, busy); end
      tick();
      total++; if (qi_cdb !== 3'd2) begin bad++; $display("[TB] FAIL cont_second_qi rep=%0d got=%0d want=2", rep, qi_cdb); end
      total++; if (cdb !== 16'h0022) begin bad++; $display("[TB] FAIL cont_second_cdb rep=%0d got=%h want=0022", rep, cdb); end
      total++; if (cdb_valid !== 1'b1) begin bad++; $display("[TB] FAIL cont_back_to_back rep=%0d got=%b want=1", rep, cdb_valid); end
      tick();
      total++; if (cdb_valid !== 1'b0) begin bad++; $display("[TB] FAIL cont_idle rep=%0d got=%b want=0", rep, cdb_valid); end
    end
  endtask

  task automatic test_full_hold();
    do_reset();
    hold      = 1'b1;
    res_valid = 2'b10;
    res_tag   = {3'd4, 3'd0};
    res_data  = {16'h0041, 16'h0000};
    tick();
    total++; if (res_ready !== 2'b11) begin bad++; $display("[TB] FAIL full_ready_one got=%b want=11", res_ready); end
    res_tag  = {3'd5, 3'd0};
    res_data = {16'h0042, 16'h0000};
    tick();
    total++; if (res_ready !== 2'b01) begin bad++; $display("[TB] FAIL full_ready_drop got=%b want=01", res_ready); end
    total++; if (cdb_valid !== 1'b0) begin bad++; $display("[TB] FAIL full_hold_valid got=%b want=0", cdb_valid); end
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL full_busy got=%b want=1", busy); end
    res_tag  = {3'd6, 3'd0};
    res_data = {16'h0043, 16'h0000};
    for (int c = 0; c < 2; c++) begin
      tick();
      total++; if (res_ready !== 2'b01) begin bad++; $display("[TB] FAIL full_ready_held cyc=%0d got=%b want=01", c, res_ready); end
      total++; if (cdb_valid !== 1'b0) begin bad++; $display("[TB] FAIL full_hold_idle cyc=%0d got=%b want=0", c, cdb_valid); end
    end
    hold = 1'b0;
    tick();
    total++; if (cdb !== 16'h0041 || qi_cdb !== 3'd4 || cdb_valid !== 1'b1) begin bad++; $display("[TB] FAIL full_first got=%h/%0d/%b want=0041/4/1", cdb, qi_cdb, cdb_valid); end
    total++; if (res_ready !== 2'b11) begin bad++; $display("[TB] FAIL full_ready_back got=%b want=11", res_ready); end
    tick();
    res_valid = 2'b00;
    total++; if (cdb !== 16'h0042 || qi_cdb !== 3'd5 || cdb_valid !== 1'b1) begin bad++; $display("[TB] FAIL full_second got=%h/%0d/%b want=0042/5/1", cdb, qi_cdb, cdb_valid); end
    tick();
    total++; if (cdb !== 16'h0043 || qi_cdb !== 3'd6 || cdb_valid !== 1'b1) begin bad++; $display("[TB] FAIL full_third got=%h/%0d/%b want=0043/6/1", cdb, qi_cdb, cdb_valid); end
    tick();
    total++; if (cdb_valid !== 1'b0) begin bad++; $display("[TB] FAIL full_drained_valid got=%b want=0", cdb_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL full_drained_busy got=%b want=0", busy); end
  endtask

  task automatic test_tag0_reset();
    do_reset();
    res_valid = 2'b01;
    res_tag   = {3'd0, 3'd0};
    res_data  = {16'h0000, 16'h0077};
    tick();
    res_valid = 2'b00;
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL tag0_busy got=%b want=0", busy); end
    total++; if (res_ready !== 2'b11) begin bad++; $display("[TB] FAIL tag0_ready got=%b want=11", res_ready); end
    tick();
    total++; if (cdb_valid !== 1'b0) begin bad++; $display("[TB] FAIL tag0_nobcast got=%b want=0", cdb_valid); end

    // Queue one result per source behind Hold, then let one broadcast.
    hold      = 1'b1;
    res_valid = 2'b11;
    res_tag   = {3'd2, 3'd1};
    res_data  = {16'h0202, 16'h0101};
    tick();
    res_valid = 2'b00;
    total++; if (busy !== 1'b1) begin bad++; $display("[TB] FAIL rst_pending_busy got=%b want=1", busy); end
    hold = 1'b0;
    tick();
    total++; if (cdb_valid !== 1'b1 || qi_cdb !== 3'd1 || cdb !== 16'h0101) begin bad++; $display("[TB] FAIL rst_pre_bcast got=%h/%0d/%b want=0101/1/1", cdb, qi_cdb, cdb_valid); end

    #3;
    reset = 1'b0;
    #1;
    total++; if (cdb !== 16'hFFF0) begin bad++; $display("[TB] FAIL rst_async_cdb got=%h want=fff0", cdb); end
    total++; if (qi_cdb !== 3'd0) begin bad++; $display("[TB] FAIL rst_async_qi got=%0d want=0", qi_cdb); end
    total++; if (cdb_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_async_valid got=%b want=0", cdb_valid); end
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_async_busy got=%b want=0", busy); end
    total++; if (res_ready !== 2'b11) begin bad++; $display("[TB] FAIL rst_async_ready got=%b want=11", res_ready); end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      total++; if (cdb_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_after_valid cyc=%0d got=%b want=0", c, cdb_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL rst_after_busy cyc=%0d got=%b want=0", c, busy); end
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b0;
    res_valid = 2'b00;
    res_tag   = '0;
    res_data  = '0;
    hold      = 1'b0;
    test_reset();
    test_single();
    test_contention();
    test_full_hold();
    test_tag0_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
